tm_port_scheduler: RTL and testbench

Traffic-manager egress scheduler that sits between the match-action pipeline output (header plus out-port bitmask) and the per-port egress logic. It buffers up to DEPTH headers in a FIFO and replicates the head header to each port in its bitmask, one port per cycle. Port selection is round-robin among ports that are both pending and ready. Headers with an empty bitmask are dropped and counted.

---
 rtl/tm_pkg.sv | 33 +++
 rtl/tm_rr_arbiter.sv | 31 +++
 rtl/tm_port_scheduler.sv | 113 +++++++++++
 tb/tb_tm_port_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared build constants plus the index width and bit-vector helpers used by the
// port scheduler and its round-robin arbiter.
`ifndef TM_DEF_SVH
`define TM_DEF_SVH
`define NUM_PORTS   4
`define BYTE_BUS    8
`define HDR_MAX_LEN 4
`define TRUE        1'b1
`define FALSE       1'b0
`endif

package tm_pkg;

  localparam int NUM_PORTS   = `NUM_PORTS;
  localparam int BYTE_BUS    = `BYTE_BUS;
  localparam int HDR_MAX_LEN = `HDR_MAX_LEN;
  localparam int HDR_W       = BYTE_BUS * HDR_MAX_LEN;
  localparam int PORT_W      = $clog2(NUM_PORTS);

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PORT_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = `TRUE;
  endfunction

  // Bit i of the result is bit (i + amt) mod NUM_PORTS of v.
  function automatic logic [NUM_PORTS-1:0] rotate_right(input logic [NUM_PORTS-1:0] v,
                                                        input logic [PORT_W-1:0]    amt);
    for (int i = 0; i < NUM_PORTS; i++) begin
      rotate_right[i] = v[(i + int'(amt)) % NUM_PORTS];
    end
  endfunction

endpackage

// File: rtl/tm_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, searching
// cyclically upward.
module tm_rr_arbiter
  import tm_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic                 gnt_valid,
  output logic [PORT_W-1:0]    gnt_idx,
  output logic [NUM_PORTS-1:0] gnt_onehot
);

  logic [NUM_PORTS-1:0] rot;
  logic [PORT_W-1:0]    offset;

  assign rot = rotate_right(req, ptr);

  always_comb begin
    offset = '0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = PORT_W'(i);
      end
    end
    gnt_valid  = |req;
    gnt_idx    = PORT_W'((int'(offset) + int'(ptr)) % NUM_PORTS);
    gnt_onehot = gnt_valid ? onehot(gnt_idx) : '0;
  end

endmodule

// File: rtl/tm_port_scheduler.sv
// Egress scheduler: header FIFO with per-entry pending port masks; the head is
// replicated one port per cycle in round-robin order, zero-mask headers are counted.
module tm_port_scheduler
  import tm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_PORTS-1:0]       in_out_port,
  input  logic [HDR_W-1:0]           in_pkt_hdr,
  input  logic [NUM_PORTS-1:0]       egress_ready,
  output logic                       out_valid,
  output logic [NUM_PORTS-1:0]       out_port,
  output logic [HDR_W-1:0]           out_pkt_hdr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [HDR_W-1:0]     hdr_mem  [DEPTH];
  logic [NUM_PORTS-1:0] pend_mem [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PORT_W-1:0]    rr_ptr_reg;
  logic                 out_valid_reg;
  logic [NUM_PORTS-1:0] out_port_reg;
  logic [HDR_W-1:0]     out_hdr_reg;
  logic [CNT_W-1:0]     drop_cnt_reg;

  logic [AW-1:0]        wr_idx, rd_idx;
  logic                 empty, full;
  logic [NUM_PORTS-1:0] head_mask, eligible, remaining;
  logic                 gnt_valid;
  logic [PORT_W-1:0]    gnt_idx;
  logic [NUM_PORTS-1:0] gnt_onehot;
  logic                 accept, push, drop, pop;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

  assign head_mask = pend_mem[rd_idx];
  assign eligible  = empty ? '0 : (head_mask & egress_ready);

  tm_rr_arbiter u_arb (
    .req        (eligible),
    .ptr        (rr_ptr_reg),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  assign remaining = head_mask & ~gnt_onehot;
  assign pop       = gnt_valid && (remaining == '0);
  assign accept    = in_valid && !full;
  assign push      = accept && (in_out_port != '0);
  assign drop      = accept && (in_out_port == '0);

  // Storage carries no reset: validity is defined by the pointers alone.
  // Push and grant never address the same slot (that needs empty or full).
  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_idx]  <= in_pkt_hdr;
      pend_mem[wr_idx] <= in_out_port;
    end
    if (gnt_valid) begin
      pend_mem[rd_idx] <= remaining;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_port_reg  <= '0;
      out_hdr_reg   <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      out_valid_reg <= gnt_valid;
      if (gnt_valid) begin
        out_port_reg <= gnt_onehot;
        out_hdr_reg  <= hdr_mem[rd_idx];
        rr_ptr_reg   <= PORT_W'((int'(gnt_idx) + 1) % NUM_PORTS);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign in_ready    = !full;
  assign out_valid   = out_valid_reg;
  assign out_port    = out_port_reg;
  assign out_pkt_hdr = out_hdr_reg;
  assign occupancy   = wr_ptr_reg - rd_ptr_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_tm_port_scheduler.sv
// Self-checking bench for tm_port_scheduler: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the scheduling rules.
module tb_tm_port_scheduler;
  import tm_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int DMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_out_port = '0;
  logic [HDR_W-1:0] in_pkt_hdr = '0;
  logic [3:0]       egress_ready = '0;
  logic             out_valid;
  logic [3:0]       out_port;
  logic [HDR_W-1:0] out_pkt_hdr;
  logic [OW-1:0]    occupancy;
  logic [CNT_W-1:0] drop_cnt;

  tm_port_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_out_port(in_out_port), .in_pkt_hdr(in_pkt_hdr), .egress_ready(egress_ready),
    .out_valid(out_valid), .out_port(out_port), .out_pkt_hdr(out_pkt_hdr),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of (header, remaining ports), round-robin start, drops.
  logic [HDR_W-1:0] mq_hdr[$];
  logic [3:0]       mq_mask[$];
  int               m_rr;
  int               m_drop;
  logic             e_valid;
  logic [3:0]       e_port;
  logic [HDR_W-1:0] e_hdr;

  task automatic model_clear();
    mq_hdr.delete();
    mq_mask.delete();
    m_rr = 0; m_drop = 0;
    e_valid = 1'b0; e_port = '0; e_hdr = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int         g;
    logic [3:0] elig;
    logic [3:0] m;
    bit         acc;
    acc = in_valid && (mq_hdr.size() < DEPTH);
    g = -1;
    e_valid = 1'b0;
    if (mq_hdr.size() > 0) begin
      elig = mq_mask[0] & egress_ready;
      for (int i = 0; i < 4; i++) begin
        if (g < 0 && elig[(m_rr + i) % 4]) g = (m_rr + i) % 4;
      end
    end
    if (g >= 0) begin
      e_valid = 1'b1;
      e_port  = 4'(1 << g);
      e_hdr   = mq_hdr[0];
      m = mq_mask[0];
      m[g] = 1'b0;
      mq_mask[0] = m;
      m_rr = (g + 1) % 4;
      if (m == 4'b0000) begin
        void'(mq_hdr.pop_front());
        void'(mq_mask.pop_front());
      end
    end
    if (acc) begin
      if (in_out_port != 4'b0000) begin
        mq_hdr.push_back(in_pkt_hdr);
        mq_mask.push_back(in_out_port);
      end else if (m_drop < DMAX) begin
        m_drop++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (out_valid) $display("copy port=%b hdr=%h occ=%0d drops=%0d", out_port, out_pkt_hdr, occupancy, drop_cnt);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_out_port = '0; egress_ready = '0;
    rst = 1'b0;
    model_clear();
    #2;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    model_clear();
    #2;
    n_checks += 6;
    if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (out_port !== 4'b0000) begin n_fail++; $display("FAIL reset out_port got %b want 0000", out_port); end
    if (out_pkt_hdr !== '0)   begin n_fail++; $display("FAIL reset out_pkt_hdr got %h want 0", out_pkt_hdr); end
    if (occupancy !== '0)     begin n_fail++; $display("FAIL reset occupancy got %0d want 0", occupancy); end
    if (drop_cnt !== '0)      begin n_fail++; $display("FAIL reset drop_cnt got %0d want 0", drop_cnt); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_unicast();
    int copies = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0); in_out_port = 4'b0001; in_pkt_hdr = $urandom; egress_ready = 4'b1111;
      tick();
      if (out_valid) copies++;
      n_checks += 4;
      if (out_valid !== e_valid) begin n_fail++; $display("FAIL unicast out_valid got %b want %b", out_valid, e_valid); end
      if (e_valid && out_port !== e_port) begin n_fail++; $display("FAIL unicast out_port got %b want %b", out_port, e_port); end
      if (e_valid && out_pkt_hdr !== e_hdr) begin n_fail++; $display("FAIL unicast hdr got %h want %h", out_pkt_hdr, e_hdr); end
      if (occupancy !== OW'(mq_hdr.size())) begin n_fail++; $display("FAIL unicast occupancy got %0d want %0d", occupancy, mq_hdr.size()); end
    end
    n_checks += 2;
    if (copies != 1) begin n_fail++; $display("FAIL unicast copies got %0d want 1", copies); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL unicast final occupancy got %0d want 0", occupancy); end
  endtask

  task automatic test_multicast();
    logic [3:0] seen[$];
    logic [3:0] want[3];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b1000;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0); in_out_port = 4'b1011; in_pkt_hdr = $urandom; egress_ready = 4'b1111;
      tick();
      if (out_valid) seen.push_back(out_port);
      n_checks += 3;
      if (out_valid !== e_valid) begin n_fail++; $display("FAIL multicast out_valid got %b want %b", out_valid, e_valid); end
      if (e_valid && out_pkt_hdr !== e_hdr) begin n_fail++; $display("FAIL multicast hdr got %h want %h", out_pkt_hdr, e_hdr); end
      if (occupancy !== OW'(mq_hdr.size())) begin n_fail++; $display("FAIL multicast occupancy got %0d want %0d", occupancy, mq_hdr.size()); end
    end
    n_checks++;
    if (seen.size() != 3) begin n_fail++; $display("FAIL multicast copy count got %0d want 3", seen.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seen[i] !== want[i]) begin n_fail++; $display("FAIL multicast order[%0d] got %b want %b", i, seen[i], want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy[5];
    logic       want_v[5];
    logic [3:0] want_p[5];
    rdy[0] = 4'b0100; rdy[1] = 4'b0100; rdy[2] = 4'b0100; rdy[3] = 4'b0010; rdy[4] = 4'b0010;
    want_v[0] = 0; want_v[1] = 1; want_v[2] = 0; want_v[3] = 1; want_v[4] = 0;
    want_p[1] = 4'b0100; want_p[3] = 4'b0010;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0); in_out_port = 4'b0110; in_pkt_hdr = $urandom; egress_ready = rdy[c];
      tick();
      n_checks += 4;
      if (out_valid !== want_v[c]) begin n_fail++; $display("FAIL backpressure c%0d out_valid got %b want %b", c, out_valid, want_v[c]); end
      if (out_valid !== e_valid) begin n_fail++; $display("FAIL backpressure c%0d model out_valid got %b want %b", c, out_valid, e_valid); end
      if (want_v[c] && out_port !== want_p[c]) begin n_fail++; $display("FAIL backpressure c%0d out_port got %b want %b", c, out_port, want_p[c]); end
      if (occupancy !== OW'(mq_hdr.size())) begin n_fail++; $display("FAIL backpressure c%0d occupancy got %0d want %0d", c, occupancy, mq_hdr.size()); end
    end
  endtask

  task automatic test_full();
    logic [3:0]       masks[5];
    logic [HDR_W-1:0] hdrs[5];
    logic [HDR_W-1:0] exp_seq[$];
    logic [HDR_W-1:0] got_seq[$];
    masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1000; masks[3] = 4'b0101; masks[4] = 4'b1111;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      hdrs[c] = $urandom;
      in_valid = 1'b1; in_out_port = masks[c]; in_pkt_hdr = hdrs[c]; egress_ready = 4'b0000;
      tick();
      n_checks += 2;
      if (in_ready !== (mq_hdr.size() < DEPTH)) begin n_fail++; $display("FAIL full c%0d in_ready got %b want %b", c, in_ready, mq_hdr.size() < DEPTH); end
      if (occupancy !== OW'(mq_hdr.size())) begin n_fail++; $display("FAIL full c%0d occupancy got %0d want %0d", c, occupancy, mq_hdr.size()); end
    end
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full in_ready got %b want 0", in_ready); end
    if (occupancy !== OW'(4)) begin n_fail++; $display("FAIL full occupancy got %0d want 4", occupancy); end
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < $countones(masks[i]); b++) exp_seq.push_back(hdrs[i]);
    end
    in_valid = 1'b0;
    egress_ready = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) got_seq.push_back(out_pkt_hdr);
      n_checks++;
      if (out_valid !== e_valid) begin n_fail++; $display("FAIL full drain out_valid got %b want %b", out_valid, e_valid); end
    end
    n_checks += 2;
    if (got_seq != exp_seq) begin n_fail++; $display("FAIL full drain order got %0d copies want %0d in FIFO order", got_seq.size(), exp_seq.size()); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full in_ready after drain got %b want 1", in_ready); end
  endtask

  task automatic test_drops();
    int any_valid = 0;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_out_port = 4'b0000; in_pkt_hdr = $urandom; egress_ready = 4'b1111;
      tick();
      if (out_valid) any_valid++;
    end
    n_checks += 3;
    if (drop_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL drops count got %0d want 3", drop_cnt); end
    if (any_valid != 0) begin n_fail++; $display("FAIL drops out_valid cycles got %0d want 0", any_valid); end
    if (occupancy !== '0) begin n_fail++; $display("FAIL drops occupancy got %0d want 0", occupancy); end
    for (int c = 0; c < DMAX + 5; c++) begin
      in_pkt_hdr = $urandom;
      tick();
    end
    n_checks += 2;
    if (drop_cnt !== '1) begin n_fail++; $display("FAIL drops saturation got %0d want %0d", drop_cnt, DMAX); end
    if (drop_cnt !== CNT_W'(m_drop)) begin n_fail++; $display("FAIL drops model got %0d want %0d", drop_cnt, m_drop); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] masks[3];
    masks[0] = 4'b1111; masks[1] = 4'b0011; masks[2] = 4'b0000;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_out_port = masks[c]; in_pkt_hdr = $urandom; egress_ready = 4'b1111;
      tick();
    end
    n_checks += 2;
    if (occupancy !== OW'(2)) begin n_fail++; $display("FAIL reset_mid queued got %0d want 2", occupancy); end
    if (drop_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL reset_mid pre drop_cnt got %0d want 1", drop_cnt); end
    in_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid got %b want 0", out_valid); end
    if (occupancy !== '0)   begin n_fail++; $display("FAIL reset_mid occupancy got %0d want 0", occupancy); end
    if (drop_cnt !== '0)    begin n_fail++; $display("FAIL reset_mid drop_cnt got %0d want 0", drop_cnt); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_mid in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid stale out_valid got %b want 0", out_valid); end
      if (occupancy !== '0)   begin n_fail++; $display("FAIL reset_mid post occupancy got %0d want 0", occupancy); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid     = ($urandom_range(3, 0) != 0);
      in_out_port  = ($urandom_range(7, 0) == 0) ? 4'b0000 : 4'($urandom);
      in_pkt_hdr   = $urandom;
      egress_ready = 4'($urandom);
      tick();
      n_checks += 4;
      if (out_valid !== e_valid) begin n_fail++; $display("FAIL random c%0d out_valid got %b want %b", c, out_valid, e_valid); end
      if (occupancy !== OW'(mq_hdr.size())) begin n_fail++; $display("FAIL random c%0d occupancy got %0d want %0d", c, occupancy, mq_hdr.size()); end
      if (in_ready !== (mq_hdr.size() < DEPTH)) begin n_fail++; $display("FAIL random c%0d in_ready got %b want %b", c, in_ready, mq_hdr.size() < DEPTH); end
      if (drop_cnt !== CNT_W'(m_drop)) begin n_fail++; $display("FAIL random c%0d drop_cnt got %0d want %0d", c, drop_cnt, m_drop); end
      if (e_valid) begin
        n_checks += 2;
        if (out_port !== e_port) begin n_fail++; $display("FAIL random c%0d out_port got %b want %b", c, out_port, e_port); end
        if (out_pkt_hdr !== e_hdr) begin n_fail++; $display("FAIL random c%0d hdr got %h want %h", c, out_pkt_hdr, e_hdr); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_full();
    test_drops();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
